// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store bus between core (master) and data memory responder (slave)
// Ports:
//   i_memReq     request valid, held by the core until o_ready
//   i_memWrite   1 = store, 0 = load
//   i_funct3     [1:0] size (byte/half/word/illegal), [2] zero-extend load
//   i_addr       byte address
//   i_writeData  store data (low bits for byte/half)
//   o_ready      one-cycle completion pulse
//   o_readData   extended load data while o_ready, else 0
//   o_busy       stall request to the core
//   o_misaligned error flag, valid with o_ready
interface data_mem_responder_if;
  logic        i_memReq;
  logic        i_memWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_writeData;
  logic        o_ready;
  logic [31:0] o_readData;
  logic        o_busy;
  logic        o_misaligned;

  modport master (
    output i_memReq, i_memWrite, i_funct3, i_addr, i_writeData,
    input  o_ready, o_readData, o_busy, o_misaligned
  );

  modport slave (
    input  i_memReq, i_memWrite, i_funct3, i_addr, i_writeData,
    output o_ready, o_readData, o_busy, o_misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory responder with programmable wait states
// Ports:
//   i_clk  clock, all state changes on rising edge
//   i_rst  synchronous active-high reset
//   bus    data_mem_responder_if.slave load/store bus
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          r_err;
  logic [3:0]    r_cnt;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic          r_mis;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_use_in;
  logic [AW+1:0] w_addr;
  logic [2:0]    w_f3;
  logic [31:0]   w_wd;
  logic          w_we;
  logic          w_err;
  logic          w_in_err;
  logic          w_commit;
  logic [31:0]   w_word;
  logic [31:0]   w_sh;
  logic [31:0]   w_ext;
  logic [31:0]   w_wrep;
  logic [3:0]    w_be;
  logic          w_unused;

  function automatic logic f_err(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b11) ||
           (f3[1:0] == 2'b01 && a[0]) ||
           (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  // Upper address bits alias onto the RAM and are deliberately dropped.
  assign w_unused = ^bus.i_addr;

  assign w_in_err = f_err(bus.i_funct3, bus.i_addr[1:0]);

  // With zero wait states the commit happens on the accept edge itself, so
  // the live bus inputs feed the access; otherwise the captured copies do.
  always_comb begin
    w_use_in = (r_state == S_IDLE);
    w_addr   = w_use_in ? bus.i_addr[AW+1:0] : r_addr;
    w_f3     = w_use_in ? bus.i_funct3       : r_funct3;
    w_wd     = w_use_in ? bus.i_writeData    : r_wdata;
    w_we     = w_use_in ? bus.i_memWrite     : r_we;
    w_err    = w_use_in ? w_in_err           : r_err;

    w_commit = !i_rst &&
               ((r_state == S_IDLE && bus.i_memReq && WAIT_CYCLES == 0) ||
                (r_state == S_WAIT && r_cnt == 4'd0));

    w_word = r_mem[w_addr[AW+1:2]];
    // Aligned accesses only reach here error-free, so one byte-granular
    // shift serves both byte and half lanes.
    w_sh   = w_word >> {w_addr[1:0], 3'b000};

    w_ext = 32'd0;
    if (!w_we && !w_err) begin
      case (w_f3[1:0])
        2'b00:   w_ext = {{24{~w_f3[2] & w_sh[7]}},  w_sh[7:0]};
        2'b01:   w_ext = {{16{~w_f3[2] & w_sh[15]}}, w_sh[15:0]};
        2'b10:   w_ext = w_word;
        default: w_ext = 32'd0;
      endcase
    end

    w_be   = 4'b0000;
    w_wrep = w_wd;
    case (w_f3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wrep = {4{w_wd[7:0]}};
      end
      2'b01: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wd[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_commit && w_we && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_addr[AW+1:2]][8*k +: 8] <= w_wrep[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_ready  <= 1'b0;
      r_rdata  <= 32'd0;
      r_mis    <= 1'b0;
      r_addr   <= '0;
      r_funct3 <= 3'd0;
      r_wdata  <= 32'd0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_mis   <= 1'b0;
          if (bus.i_memReq) begin
            r_addr   <= bus.i_addr[AW+1:0];
            r_funct3 <= bus.i_funct3;
            r_wdata  <= bus.i_writeData;
            r_we     <= bus.i_memWrite;
            r_err    <= w_in_err;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_rdata <= w_ext;
              r_mis   <= w_in_err;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_rdata <= w_ext;
            r_mis   <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_mis   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_IDLE:  bus.o_busy = bus.i_memReq;
      S_WAIT:  bus.o_busy = 1'b1;
      default: bus.o_busy = 1'b0;
    endcase
  end

  assign bus.o_ready      = r_ready;
  assign bus.o_readData   = r_rdata;
  assign bus.o_misaligned = r_mis;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder at 0, 1 and 3 wait states
module tb_data_mem_responder;
  logic        clk;
  logic        rst0, rst1, rst3;
  logic        req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  int          sel;
  int          wc;
  int          checks;
  int          failures;

  logic        ready, busy, mis;
  logic [31:0] rdata;
  logic [31:0] got_rd;
  logic        got_mis;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus3 ();

  assign bus0.i_memReq = req & (sel == 0);
  assign bus1.i_memReq = req & (sel == 1);
  assign bus3.i_memReq = req & (sel == 3);
  assign bus0.i_memWrite = we;  assign bus1.i_memWrite = we;  assign bus3.i_memWrite = we;
  assign bus0.i_funct3 = f3;    assign bus1.i_funct3 = f3;    assign bus3.i_funct3 = f3;
  assign bus0.i_addr = addr;    assign bus1.i_addr = addr;    assign bus3.i_addr = addr;
  assign bus0.i_writeData = wd; assign bus1.i_writeData = wd; assign bus3.i_writeData = wd;

  assign ready = (sel == 0) ? bus0.o_ready      : (sel == 1) ? bus1.o_ready      : bus3.o_ready;
  assign busy  = (sel == 0) ? bus0.o_busy       : (sel == 1) ? bus1.o_busy       : bus3.o_busy;
  assign mis   = (sel == 0) ? bus0.o_misaligned : (sel == 1) ? bus1.o_misaligned : bus3.o_misaligned;
  assign rdata = (sel == 0) ? bus0.o_readData   : (sel == 1) ? bus1.o_readData   : bus3.o_readData;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (.i_clk(clk), .i_rst(rst0), .bus(bus0));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (.i_clk(clk), .i_rst(rst1), .bus(bus1));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (.i_clk(clk), .i_rst(rst3), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance; inputs are scrambled right after
  // accept to show the captured copy is what gets used.
  task automatic do_access(input string tag, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_mis);
    @(negedge clk);
    req = 1'b1; we = w; f3 = f; addr = a; wd = d;
    #1 chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    addr = a ^ 32'h0000_0004; wd = ~d; f3 = f ^ 3'b100;
    for (int i = 0; i < wc; i++) begin
      chk({tag, "_ready_wait"}, {31'd0, ready}, 32'd0);
      chk({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_busy_resp"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mis"}, {31'd0, mis}, {31'd0, exp_mis});
    if (!w) chk({tag, "_rdata"}, rdata, exp_rd);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_ready_after"}, {31'd0, ready}, 32'd0);
    chk({tag, "_rdata_after"}, rdata, 32'd0);
  endtask

  // Request held high: ready must pulse once per 2+wc cycles, busy elsewhere.
  task automatic held_sweep(input string tag);
    @(negedge clk);
    req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h20; wd = 32'd0;
    @(posedge clk);
    for (int j = 0; j < 3 * (2 + wc); j++) begin
      #1;
      chk({tag, "_ready"}, {31'd0, ready}, {31'd0, (j % (2 + wc)) == wc});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (j % (2 + wc)) != wc});
      if ((j % (2 + wc)) == wc) chk({tag, "_rdata"}, rdata, 32'h1122_3344);
      @(posedge clk);
    end
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    req = 1'b0; we = 1'b0; f3 = 3'b010; addr = 32'd0; wd = 32'd0;
    sel = 1; wc = 1;
    rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;

    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        sel = s;
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_mis", {31'd0, mis}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
      end
    end

    sel = 1; wc = 1;
    do_access("sw_word",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_access("lw_word",  1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_access("lb_13",    1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0);
    do_access("lbu_13",   1'b0, 3'b100, 32'h13, 32'd0, 32'h0000_00DE, 1'b0);
    do_access("lh_10",    1'b0, 3'b001, 32'h10, 32'd0, 32'hFFFF_BEEF, 1'b0);
    do_access("lhu_12",   1'b0, 3'b101, 32'h12, 32'd0, 32'h0000_DEAD, 1'b0);
    do_access("sb_11",    1'b1, 3'b000, 32'h11, 32'h0000_0055, 32'd0, 1'b0);
    do_access("lw_sb",    1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_55EF, 1'b0);
    do_access("sh_12",    1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'd0, 1'b0);
    do_access("lw_sh",    1'b0, 3'b010, 32'h10, 32'd0, 32'h1234_55EF, 1'b0);
    do_access("lw_mis",   1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1);
    do_access("sh_mis",   1'b1, 3'b001, 32'h11, 32'h0000_FFFF, 32'd0, 1'b1);
    do_access("lw_after", 1'b0, 3'b010, 32'h10, 32'd0, 32'h1234_55EF, 1'b0);
    do_access("illegal",  1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);
    do_access("lw_alias", 1'b0, 3'b010, 32'h0001_1010, 32'd0, 32'h1234_55EF, 1'b0);

    sel = 0; wc = 0;
    do_access("w0_sw", 1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'd0, 1'b0);
    do_access("w0_lb", 1'b0, 3'b000, 32'h22, 32'd0, 32'h0000_0022, 1'b0);
    held_sweep("w0_held");

    sel = 3; wc = 3;
    do_access("w3_sw", 1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'd0, 1'b0);
    held_sweep("w3_held");

    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h20; wd = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b1; req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("rst_no_ready", {31'd0, ready}, 32'd0);
    end
    do_access("rst_lw", 1'b0, 3'b010, 32'h20, 32'd0, 32'h1122_3344, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's load/store interface: accepts `i_memReq`/`i_memWrite` requests with RV32I `funct3` size/sign encoding.
- Performs the access on an internal word-organised RAM and returns extended load data with a one-cycle `o_ready` pulse.
- Wait states are programmable; the core stalls on `o_busy`.
- Sits between the datapath's memory-stage signals and on-chip data storage.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 1: extra cycles between accept and response; range 0..15.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_memReq  in  1  request valid; held by core until `o_ready`.
- i_memWrite  in  1  1 = store, 0 = load; sampled with `i_memReq`.
- i_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] = 1 zero-extend load.
- i_addr  in  32  byte address.
- i_writeData  in  32  store data; low bits used for byte/half stores.
- o_ready  out  1  one-cycle completion pulse.
- o_readData  out  32  extended load data; valid while `o_ready` = 1, otherwise 0.
- o_busy  out  1  stall request to core.
- o_misaligned  out  1  error flag, valid with `o_ready`.

Behaviour:
- FSM states:
  - IDLE, WAIT, RESP.
  - Internal registers: captured addr/funct3/data/we, 4-bit wait counter, error flag.
- Reset (`i_rst` = 1 at edge):
  - state ← IDLE, counter ← 0.
  - `o_ready`, `o_readData`, `o_misaligned` ← 0.
  - RAM contents are not initialised by reset.
- IDLE:
  - `o_busy` = `i_memReq` (combinational).
  - If `i_memReq` = 1 at edge: capture all inputs and evaluate the error condition.
  - Error condition: size 11, half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 00.
  - Next state: WAIT if WAIT_CYCLES > 0 (counter ← WAIT_CYCLES−1), else RESP.
- WAIT:
  - `o_busy` = 1.
  - Counter decrements each cycle; at counter = 0, next state is RESP.
- Memory commit:
  - Occurs on the edge entering RESP.
  - Store, no error: write the enabled byte lanes only.
    - Byte: lane `addr[1:0]` gets `writeData[7:0]`.
    - Half: lanes {`addr[1]`,0} and {`addr[1]`,1} get `writeData[15:0]`.
    - Word: all four lanes.
  - Load, no error: register the selected lane(s).
    - Sign-extend when `funct3[2]` = 0, zero-extend when 1; word loads ignore `funct3[2]`.
  - Error: no RAM write; `o_readData` = 0; `o_misaligned` = 1.
- RESP:
  - Lasts exactly one cycle: `o_ready` = 1, `o_busy` = 0.
  - `i_memReq` is ignored in this cycle; next state is IDLE.
  - Core's next request is accepted no earlier than the following cycle.
- Latency: accept at edge T → `o_ready` high during cycle T+1+WAIT_CYCLES.
- Throughput: one access per 2+WAIT_CYCLES cycles.
- Addressing:
  - Word index = `addr[log2(DEPTH_WORDS)+1:2]`.
  - Upper address bits are ignored (aliasing wraps, no error).
- Input stability: `i_addr`, `i_funct3`, `i_memWrite`, `i_writeData` changing after accept have no effect.
- Reset mid-operation (in WAIT): the pending store is dropped (RAM unchanged) and no `o_ready` is issued.
- Error response timing: an errored request still takes the full WAIT_CYCLES latency.

Test Plan:
- Word round trip, WAIT_CYCLES = 1:
  - Store `i_writeData` = 0xDEADBEEF to 0x0000_0010, then load word from 0x10.
  - Expect `o_ready` 2 cycles after each accept, `o_readData` = 0xDEADBEEF, `o_misaligned` = 0.
- Byte/half extension:
  - After the word above, LB at 0x13 → 0xFFFFFFDE; LBU at 0x13 → 0x000000DE.
  - LH at 0x10 → 0xFFFFBEEF; LHU at 0x12 → 0x0000DEAD.
- Partial store:
  - SB 0x55 to 0x11, then LW 0x10 → 0xDEAD55EF.
  - SH 0x1234 to 0x12, then LW 0x10 → 0x123455EF.
- Misaligned and illegal accesses:
  - LW at 0x0000_0012 → `o_ready` with `o_misaligned` = 1, `o_readData` = 0.
  - SH at 0x11 → `o_misaligned` = 1, and a subsequent LW 0x10 is unchanged.
  - `funct3` = 011 → `o_misaligned` = 1.
- Latency sweep and handshake:
  - With WAIT_CYCLES = 0 and 3, back-to-back held `i_memReq`.
  - Expect `o_ready` at T+1 and T+4, `o_busy` high from accept until RESP, and one access per 2 and 5 cycles respectively.
- Reset mid-store:
  - With WAIT_CYCLES = 3, SW 0xAAAAAAAA to 0x20, assert `i_rst` one cycle after accept.
  - Expect no `o_ready`, all outputs 0; a later LW 0x20 returns the prior contents.
